// File: rtl/dlf16_int_accumulator.sv
// Frame accumulator for converted float16 samples: sums signed 32-bit beats with
// saturation and holds each frame result until the downstream consumer takes it.
module dlf16_int_accumulator #(
   parameter int unsigned FRAME_LEN = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic [7:0]  out_count,
   output logic        out_sat
);

   localparam logic [7:0] FRAME_LEN_U8 = 8'(FRAME_LEN);

   typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

   state_t      state_reg, state_next;
   logic [31:0] acc_reg, acc_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        sat_reg, sat_next;
   logic [31:0] out_sum_reg, out_sum_next;
   logic [7:0]  out_count_reg, out_count_next;
   logic        out_sat_reg, out_sat_next;

   logic        accept;
   logic [32:0] sum_wide;
   logic        ovf_pos, ovf_neg;
   logic [31:0] sum_clamped;
   logic [7:0]  cnt_inc;
   logic        frame_end;

   assign in_ready  = (state_reg == ACCUM);
   assign out_valid = (state_reg == DONE);
   assign out_sum   = out_sum_reg;
   assign out_count = out_count_reg;
   assign out_sat   = out_sat_reg;

   assign accept   = in_valid && in_ready;
   assign sum_wide = {acc_reg[31], acc_reg} + {in_data[31], in_data};
   // Overflow shows up as the two top bits of the 33-bit sum disagreeing.
   assign ovf_pos  = !sum_wide[32] && sum_wide[31];
   assign ovf_neg  = sum_wide[32] && !sum_wide[31];
   assign cnt_inc  = cnt_reg + 8'd1;
   assign frame_end = accept && (in_last || (cnt_inc == FRAME_LEN_U8));

   always_comb begin
      sum_clamped = sum_wide[31:0];
      if (ovf_pos) begin
         sum_clamped = 32'h7FFF_FFFF;
      end else if (ovf_neg) begin
         sum_clamped = 32'h8000_0000;
      end
   end

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      sat_next       = sat_reg;
      out_sum_next   = out_sum_reg;
      out_count_next = out_count_reg;
      out_sat_next   = out_sat_reg;
      case (state_reg)
         ACCUM: begin
            if (accept) begin
               acc_next = sum_clamped;
               cnt_next = cnt_inc;
               sat_next = sat_reg || ovf_pos || ovf_neg;
               if (frame_end) begin
                  out_sum_next   = sum_clamped;
                  out_count_next = cnt_inc;
                  out_sat_next   = sat_reg || ovf_pos || ovf_neg;
                  state_next     = DONE;
               end
            end
         end
         DONE: begin
            // Result stays frozen until taken; the running state is wiped for the next frame.
            if (out_ready) begin
               acc_next   = '0;
               cnt_next   = '0;
               sat_next   = 1'b0;
               state_next = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ACCUM;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         sat_reg       <= 1'b0;
         out_sum_reg   <= '0;
         out_count_reg <= '0;
         out_sat_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         sat_reg       <= sat_next;
         out_sum_reg   <= out_sum_next;
         out_count_reg <= out_count_next;
         out_sat_reg   <= out_sat_next;
      end
   end

endmodule

// File: tb/tb_dlf16_int_accumulator.sv
// Scoreboard bench for dlf16_int_accumulator with FRAME_LEN=4: directed frames push
// hand-computed results; a negedge monitor checks each output handshake against them.
module tb_dlf16_int_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic [7:0]  out_count;
   logic        out_sat;

   typedef struct packed {
      logic [31:0] sum;
      logic [7:0]  cnt;
      logic        sat;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dlf16_int_accumulator #(.FRAME_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_sat   (out_sat)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Present one beat and hold it until accepted; returns at posedge+1 after acceptance.
   task automatic send(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         n_vec++;
         n_err++;
         $display("FAIL beat_timeout: in_ready stayed %b for 50 cycles, expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 32'hDEAD_BEEF;
   endtask

   function automatic exp_t mk(input logic [31:0] s, input logic [7:0] c, input logic t);
      exp_t e;
      e.sum = s;
      e.cnt = c;
      e.sat = t;
      return e;
   endfunction

   // Monitor: every completed output handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got sum=%h count=%0d sat=%b, expected none",
                     out_sum, out_count, out_sat);
         end else begin
            e = exp_q.pop_front();
            if (out_sum !== e.sum || out_count !== e.cnt || out_sat !== e.sat) begin
               n_err++;
               $display("FAIL result: got sum=%h count=%0d sat=%b, expected sum=%h count=%0d sat=%b",
                        out_sum, out_count, out_sat, e.sum, e.cnt, e.sat);
            end else begin
               $display("ok   result: sum=%h count=%0d sat=%b", out_sum, out_count, out_sat);
            end
         end
      end
   end

   initial begin
      int c0;
      int n;
      logic [31:0] held_sum;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("reset_in_ready",  32'(in_ready),  32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_sum",   out_sum,        32'd0);
      check("reset_out_count", 32'(out_count), 32'd0);
      check("reset_out_sat",   32'(out_sat),   32'd0);

      // Full-length frame ends on the count, result visible right after the 4th beat.
      exp_q.push_back(mk(32'd10, 8'd4, 1'b0));
      send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'd4, 1'b0);
      check("len4_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;

      // Early end via in_last, handshake then in_ready returns a cycle later.
      exp_q.push_back(mk(32'd12, 8'd2, 1'b0));
      send(32'd5, 1'b0); send(32'd7, 1'b1);
      check("last_in_ready_done", 32'(in_ready),  32'd0);
      check("last_out_valid",     32'(out_valid), 32'd1);
      @(posedge clk); #1;
      check("last_in_ready_after", 32'(in_ready), 32'd1);

      // Positive saturation is sticky; the -16 starts from the clamped value.
      exp_q.push_back(mk(32'h7FFF_FFEF, 8'd3, 1'b1));
      send(32'h7FFF_FFF0, 1'b0); send(32'h0000_0100, 1'b0); send(32'hFFFF_FFF0, 1'b1);
      @(posedge clk); #1;

      // Negative saturation at -2^31.
      exp_q.push_back(mk(32'h8000_0000, 8'd2, 1'b1));
      send(32'h8000_0000, 1'b0); send(32'hFFFF_FFFF, 1'b1);
      @(posedge clk); #1;

      // Back-pressure: result held 5 cycles while upstream keeps offering a beat.
      out_ready = 1'b0;
      exp_q.push_back(mk(32'd3, 8'd2, 1'b0));
      send(32'd1, 1'b0); send(32'd2, 1'b1);
      held_sum = out_sum;
      check("hold_initial_sum", held_sum, 32'd3);
      in_valid = 1'b1;
      in_data  = 32'd99;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_sum",       out_sum,         32'd3);
         check("hold_count",     32'(out_count),  32'd2);
         check("hold_out_valid", 32'(out_valid),  32'd1);
         check("hold_in_ready",  32'(in_ready),   32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(mk(32'd4, 8'd4, 1'b0));
      for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
      @(posedge clk); #1;

      // Reset mid-frame discards the partial sum.
      send(32'd1, 1'b0); send(32'd1, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      exp_q.push_back(mk(32'd4, 8'd4, 1'b0));
      for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
      @(posedge clk); #1;

      // Two back-to-back frames with continuous offer: FRAME_LEN+1 cycles each.
      exp_q.push_back(mk(32'd8, 8'd4, 1'b0));
      exp_q.push_back(mk(32'd8, 8'd4, 1'b0));
      c0 = cyc;
      for (int i = 0; i < 8; i++) send(32'd2, 1'b0);
      check("throughput_cycles", 32'(cyc - c0), 32'd9);

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
